// File: rtl/log_mover_if.sv
// Log mover bundle: frame tick and difficulty in,
// per-log start positions and walk status out.
interface log_mover_if #(
    parameter int NUM_OF_LOGS = 30
);
    logic        startOfFrame;
    logic        enable;
    logic [1:0]  speed_level;
    logic [10:0] ObjectStartX [NUM_OF_LOGS];
    logic [10:0] ObjectStartY [NUM_OF_LOGS];
    logic        busy;
    logic        frame_done;

    modport master (
        output startOfFrame,
        output enable,
        output speed_level,
        input  ObjectStartX,
        input  ObjectStartY,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  startOfFrame,
        input  enable,
        input  speed_level,
        output ObjectStartX,
        output ObjectStartY,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/log_mover.sv
// Log mover: owns river log positions and scrolls
// one log per clock after each start-of-frame tick.
module log_mover #(
    parameter int NUM_OF_LOGS  = 30,
    parameter int NUM_LANES    = 5,
    parameter int TRACK_LEN    = 680,
    parameter int LOG_SPACING  = 110,
    parameter int LANE_STAGGER = 23,
    parameter int LANE_Y0      = 80,
    parameter int LANE_PITCH   = 40
) (
    input  logic CLK,
    input  logic RESETn,
    log_mover_if.slave bus
);
    localparam int LPL = NUM_OF_LOGS / NUM_LANES;
    localparam int IW  = $clog2(NUM_OF_LOGS);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    state_t      state;
    logic [IW-1:0] idx;
    logic        busy_q;
    logic        done_q;
    logic [10:0] x_q [NUM_OF_LOGS];

    int          lane;
    logic [3:0]  step;
    logic [11:0] cur;
    logic [11:0] nxt;

    function automatic logic [10:0] x_init(int i);
        return 11'(((i % LPL) * LOG_SPACING
                    + (i / LPL) * LANE_STAGGER) % TRACK_LEN);
    endfunction

    // Only the log under idx is touched; the wrap keeps x in the track.
    always_comb begin
        lane = int'(idx) / LPL;
        step = 4'(1 + lane % 3) + {2'b00, bus.speed_level};
        cur  = {1'b0, x_q[idx]};
        nxt  = cur;
        if (lane % 2 == 0) begin
            nxt = cur + 12'(step);
            if (nxt >= 12'(TRACK_LEN))
                nxt = nxt - 12'(TRACK_LEN);
        end else begin
            if (cur < 12'(step))
                nxt = cur + 12'(TRACK_LEN) - 12'(step);
            else
                nxt = cur - 12'(step);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NUM_OF_LOGS; i++)
                x_q[i] <= x_init(i);
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.startOfFrame && bus.enable) begin
                        state  <= UPDATE;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                UPDATE: begin
                    x_q[idx] <= 11'(nxt);
                    if (idx == IW'(NUM_OF_LOGS - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane heights never change, so Y is wired from constants.
    genvar g;
    for (g = 0; g < NUM_OF_LOGS; g++) begin : g_y
        assign bus.ObjectStartY[g] =
            11'(LANE_Y0 + (g / LPL) * LANE_PITCH);
    end

    assign bus.ObjectStartX = x_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;
endmodule
